sdram_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single IS42S16320F SDRAM controller req/ack/valid port between
//  NUM_PORTS requesters (e.g. video fetch, CPU). Registers the winning command and holds ctrl_req until

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arb_tag_fifo.sv | 63 ++++++
 rtl/sdram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter and its tag FIFO.
// Default widths match the IS42S16320F controller port.
package sdram_arb_pkg;

    localparam int unsigned DefAddrW = 23;
    localparam int unsigned DefDataW = 32;

    typedef enum logic {
        StIdle,
        StIssue
    } arb_state_e;

    // Port-ID width; a single requester still needs one bit to index with.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// pop_err flags a pop attempted while empty; the pop itself is ignored.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [ID_W-1:0]          push_id,
    input  logic                     pop,
    output logic [ID_W-1:0]          head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     pop_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ID_W-1:0] mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CntW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_err = pop & empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller req/ack/valid port between requesters.
// Read data is steered back to its issuer through an in-order tag FIFO.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_data,
    input  logic [NUM_PORTS-1:0]          p_we,
    input  logic [NUM_PORTS-1:0]          p_req,
    output logic [NUM_PORTS-1:0]          p_ack,
    output logic [NUM_PORTS-1:0]          p_valid,
    output logic [DATA_W-1:0]             p_q,
    output logic [ADDR_W-1:0]             ctrl_addr,
    output logic [DATA_W-1:0]             ctrl_data,
    output logic                          ctrl_we,
    output logic                          ctrl_req,
    input  logic                          ctrl_ack,
    input  logic                          ctrl_valid,
    input  logic [DATA_W-1:0]             ctrl_q,
    output logic                          err_orphan
);

    localparam int unsigned IdW  = id_width(NUM_PORTS);
    localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

    arb_state_e           state;
    logic [IdW-1:0]       rr_ptr;
    logic [IdW-1:0]       grant_id;
    logic [IdW-1:0]       winner;
    logic [IdW-1:0]       rr_next;
    logic                 found;
    logic [NUM_PORTS-1:0] eligible;

    logic                 tag_push;
    logic [IdW-1:0]       tag_head;
    logic [CntW-1:0]      tag_count;
    logic                 tag_empty;
    logic                 tag_pop_err;

    // A port still showing p_ack has not had a chance to drop its request yet.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = p_req[i] & ~p_ack[i] & (p_we[i] | (tag_count < CntW'(TAG_DEPTH)));
        end
    end

    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx  = (32'(rr_ptr) + k) % NUM_PORTS;
            cand = IdW'(idx);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        rr_next = IdW'((32'(winner) + 1) % NUM_PORTS);
    end

    assign tag_push = (state == StIssue) & ctrl_ack & ~ctrl_we;

    sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .ID_W  (IdW)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tag_push),
        .push_id (grant_id),
        .pop     (ctrl_valid),
        .head    (tag_head),
        .count   (tag_count),
        .empty   (tag_empty),
        .pop_err (tag_pop_err)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            grant_id   <= '0;
            ctrl_req   <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_data  <= '0;
            ctrl_we    <= 1'b0;
            p_ack      <= '0;
            p_valid    <= '0;
            p_q        <= '0;
            err_orphan <= 1'b0;
        end else begin
            p_ack   <= '0;
            p_valid <= '0;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        grant_id  <= winner;
                        rr_ptr    <= rr_next;
                        ctrl_addr <= p_addr[32'(winner)*ADDR_W +: ADDR_W];
                        ctrl_data <= p_data[32'(winner)*DATA_W +: DATA_W];
                        ctrl_we   <= p_we[winner];
                        ctrl_req  <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (ctrl_ack) begin
                        ctrl_req        <= 1'b0;
                        p_ack[grant_id] <= 1'b1;
                        state           <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
            if (ctrl_valid && !tag_empty) begin
                p_q               <= ctrl_q;
                p_valid[tag_head] <= 1'b1;
            end
            if (tag_pop_err) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural controller, per-port requesters and an
// in-order read scoreboard, driven by a vector table, directed corner cases and random traffic.
module tb_sdram_port_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 23;
    localparam int unsigned DW = 32;
    localparam int unsigned TD = 4;

    logic             clk;
    logic             reset_n;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_data;
    logic [NP-1:0]    p_we;
    logic [NP-1:0]    p_req;
    logic [NP-1:0]    p_ack;
    logic [NP-1:0]    p_valid;
    logic [DW-1:0]    p_q;
    logic [AW-1:0]    ctrl_addr;
    logic [DW-1:0]    ctrl_data;
    logic             ctrl_we;
    logic             ctrl_req;
    logic             ctrl_ack;
    logic             ctrl_valid;
    logic [DW-1:0]    ctrl_q;
    logic             err_orphan;

    sdram_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p_addr     (p_addr),
        .p_data     (p_data),
        .p_we       (p_we),
        .p_req      (p_req),
        .p_ack      (p_ack),
        .p_valid    (p_valid),
        .p_q        (p_q),
        .ctrl_addr  (ctrl_addr),
        .ctrl_data  (ctrl_data),
        .ctrl_we    (ctrl_we),
        .ctrl_req   (ctrl_req),
        .ctrl_ack   (ctrl_ack),
        .ctrl_valid (ctrl_valid),
        .ctrl_q     (ctrl_q),
        .err_orphan (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
    } cmd_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        int unsigned   port;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        int unsigned   ack_lat;
        int unsigned   rd_lat;
        int unsigned   exp_port;
        logic [AW-1:0] exp_addr;
        logic          exp_we;
        logic [DW-1:0] exp_cdata;
        int unsigned   exp_v0;
        int unsigned   exp_v1;
        logic [DW-1:0] exp_q;
    } vec_t;

    cmd_t          port_q [NP][$];
    cmd_t          cur [NP];
    bit            active [NP];
    ret_t          pend [$];
    int unsigned   iss_q [$];
    logic [DW-1:0] exp_q [$];
    int unsigned   ack_log [$];
    int unsigned   ack_cnt [NP];
    int unsigned   valid_cnt [NP];
    cmd_t          last_cmd;
    logic [DW-1:0] last_q;
    int unsigned   cyc;
    int unsigned   ack_wait;
    int unsigned   ack_lat;
    int unsigned   rd_lo;
    int unsigned   rd_hi;
    int unsigned   gap_pct;
    bit            hold_valid;
    bit            orphan_pulse;
    bit            coincide_seen;
    int            n_checks;
    int            n_fail;

    // Controller memory contents as seen by a read: a fixed function of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0], ~a[0], a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Everything the bench does at the falling edge: monitor, controller model, requesters.
    task automatic step();
        cyc++;
        if (!reset_n) begin
            ctrl_ack     = 1'b0;
            ctrl_valid   = 1'b0;
            ack_wait     = 0;
            orphan_pulse = 1'b0;
            pend.delete();
            iss_q.delete();
            exp_q.delete();
        end else begin
            if (ctrl_ack && ctrl_valid) coincide_seen = 1'b1;
            if (p_valid != '0) begin
                for (int i = 0; i < NP; i++) if (p_valid[i]) valid_cnt[i]++;
                last_q = p_q;
                if (iss_q.size() == 0) begin
                    check("valid_orphan", 64'(p_valid), 64'd0);
                end else begin
                    check("valid_port", 64'(p_valid), 64'(NP'(1) << iss_q[0]));
                    check("valid_data", 64'(p_q), 64'(exp_q[0]));
                    void'(iss_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (p_ack[i]) begin
                    ack_cnt[i]++;
                    ack_log.push_back(i);
                    check("ack_active", 64'(active[i]), 64'd1);
                    if (active[i]) begin
                        check("ack_cmd", {8'd0, last_cmd.addr, last_cmd.we, last_cmd.data},
                              {8'd0, cur[i].addr, cur[i].we, cur[i].data});
                        if (!cur[i].we) begin
                            iss_q.push_back(i);
                            exp_q.push_back(mem_word(cur[i].addr));
                        end
                        active[i] = 1'b0;
                    end
                end
            end
            if (ctrl_ack) begin
                ctrl_ack = 1'b0;
            end else if (ctrl_req) begin
                if (ack_wait >= ack_lat) begin
                    ctrl_ack = 1'b1;
                    ack_wait = 0;
                    last_cmd = '{addr: ctrl_addr, data: ctrl_data, we: ctrl_we};
                    if (!ctrl_we) begin
                        pend.push_back('{due: cyc + $urandom_range(rd_hi, rd_lo),
                                         data: mem_word(ctrl_addr)});
                    end
                end else begin
                    ack_wait++;
                end
            end
            ctrl_valid = 1'b0;
            if (orphan_pulse) begin
                ctrl_valid   = 1'b1;
                ctrl_q       = 32'hDEAD_BEEF;
                orphan_pulse = 1'b0;
            end else if (!hold_valid && pend.size() > 0 && pend[0].due <= cyc) begin
                ctrl_valid = 1'b1;
                ctrl_q     = pend[0].data;
                void'(pend.pop_front());
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!active[i] && port_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                cur[i]    = port_q[i].pop_front();
                active[i] = 1'b1;
            end
            p_req[i] = active[i];
            if (active[i]) begin
                p_addr[i*AW +: AW] = cur[i].addr;
                p_data[i*DW +: DW] = cur[i].data;
                p_we[i]            = cur[i].we;
            end
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(negedge clk);
            step();
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = ctrl_req || pend.size() > 0 || iss_q.size() > 0;
        for (int i = 0; i < NP; i++) b = b || active[i] || port_q[i].size() > 0;
        return b;
    endfunction

    task automatic wait_drain(input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        tick(2);
        check({name, "_drain"}, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_acks(input int unsigned port, input int unsigned cnt,
                             input int unsigned budget, input string name);
        int unsigned n;
        n = 0;
        while (ack_cnt[port] < cnt && n < budget) begin
            tick();
            n++;
        end
        check({name, "_ack_wait"}, 64'(n < budget), 64'd1);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NP; i++) begin
            port_q[i].delete();
            ack_cnt[i]   = 0;
            valid_cnt[i] = 0;
        end
        ack_log.delete();
        last_q        = '0;
        last_cmd      = '{addr: '0, data: '0, we: 1'b0};
        coincide_seen = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ctrl_req"}, 64'(ctrl_req), 64'd0);
        check({pfx, "_ctrl_addr"}, 64'(ctrl_addr), 64'd0);
        check({pfx, "_ctrl_data"}, 64'(ctrl_data), 64'd0);
        check({pfx, "_ctrl_we"}, 64'(ctrl_we), 64'd0);
        check({pfx, "_p_ack"}, 64'(p_ack), 64'd0);
        check({pfx, "_p_valid"}, 64'(p_valid), 64'd0);
        check({pfx, "_p_q"}, 64'(p_q), 64'd0);
        check({pfx, "_err_orphan"}, 64'(err_orphan), 64'd0);
    endtask

    vec_t vecs [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        p_addr   = '0;
        p_data   = '0;
        p_we     = '0;
        p_req    = '0;
        ctrl_ack = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_q   = '0;
        ack_wait = 0;
        ack_lat  = 0;
        rd_lo    = 2;
        rd_hi    = 2;
        gap_pct  = 0;
        hold_valid   = 1'b0;
        orphan_pulse = 1'b0;
        for (int i = 0; i < NP; i++) active[i] = 1'b0;
        clear_bench();

        vecs[0] = '{0, 23'h1FF, 1'b0, 32'h0, 0, 3,
                    0, 23'h1FF, 1'b0, 32'h0, 1, 0, mem_word(23'h1FF)};
        vecs[1] = '{1, 23'h7FFFFF, 1'b1, 32'hA5A5_5A5A, 2, 1,
                    1, 23'h7FFFFF, 1'b1, 32'hA5A5_5A5A, 0, 0, 32'h0};
        vecs[2] = '{1, 23'h0, 1'b0, 32'h1234_5678, 5, 1,
                    1, 23'h0, 1'b0, 32'h1234_5678, 0, 1, mem_word(23'h0)};
        vecs[3] = '{0, 23'h123456, 1'b1, 32'hFFFF_FFFF, 1, 2,
                    0, 23'h123456, 1'b1, 32'hFFFF_FFFF, 0, 0, 32'h0};

        tick(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 4; v++) begin
            clear_bench();
            ack_lat = vecs[v].ack_lat;
            rd_lo   = vecs[v].rd_lat;
            rd_hi   = vecs[v].rd_lat;
            port_q[vecs[v].port].push_back('{addr: vecs[v].addr, data: vecs[v].data,
                                             we: vecs[v].we});
            wait_drain(200, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_ack_count", v), 64'(ack_log.size()), 64'd1);
            if (ack_log.size() > 0) begin
                check($sformatf("vec%0d_ack_port", v), 64'(ack_log[0]), 64'(vecs[v].exp_port));
            end
            check($sformatf("vec%0d_ctrl_addr", v), 64'(last_cmd.addr), 64'(vecs[v].exp_addr));
            check($sformatf("vec%0d_ctrl_we", v), 64'(last_cmd.we), 64'(vecs[v].exp_we));
            check($sformatf("vec%0d_ctrl_data", v), 64'(last_cmd.data), 64'(vecs[v].exp_cdata));
            check($sformatf("vec%0d_valid0", v), 64'(valid_cnt[0]), 64'(vecs[v].exp_v0));
            check($sformatf("vec%0d_valid1", v), 64'(valid_cnt[1]), 64'(vecs[v].exp_v1));
            check($sformatf("vec%0d_q", v), 64'(last_q), 64'(vecs[v].exp_q));
        end

        // Contention: both ports requesting from reset must alternate 0,1,0,1...
        clear_bench();
        reset_n = 1'b0;
        ack_lat = 0;
        rd_lo   = 2;
        rd_hi   = 4;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NP; i++) begin
                port_q[i].push_back('{addr: AW'($urandom), data: $urandom, we: 1'b0});
            end
        end
        tick(2);
        reset_n = 1'b1;
        wait_drain(400, "contend");
        check("contend_acks", 64'(ack_log.size()), 64'd8);
        for (int k = 0; k < ack_log.size(); k++) begin
            check($sformatf("contend_grant%0d", k), 64'(ack_log[k]), 64'(k % 2));
        end
        check("contend_valid0", 64'(valid_cnt[0]), 64'd4);
        check("contend_valid1", 64'(valid_cnt[1]), 64'd4);

        // Tag FIFO full: fifth read waits for a return, a write on the other port does not.
        clear_bench();
        hold_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            port_q[0].push_back('{addr: AW'(k * 16 + 3), data: '0, we: 1'b0});
        end
        wait_acks(0, 4, 100, "full");
        tick(10);
        check("full_read_acks", 64'(ack_cnt[0]), 64'd4);
        check("full_no_issue", 64'(ctrl_req), 64'd0);
        port_q[1].push_back('{addr: 23'h55AA, data: 32'hCAFE_F00D, we: 1'b1});
        wait_acks(1, 1, 50, "full_write");
        check("full_write_acked", 64'(ack_cnt[1]), 64'd1);
        check("full_write_addr", 64'(last_cmd.addr), 64'h55AA);
        check("full_read_still4", 64'(ack_cnt[0]), 64'd4);
        hold_valid = 1'b0;
        wait_drain(200, "full");
        check("full_read_acks_end", 64'(ack_cnt[0]), 64'd5);
        check("full_valid0", 64'(valid_cnt[0]), 64'd5);
        check("full_valid1", 64'(valid_cnt[1]), 64'd0);

        // Read ack coinciding with a read return: push and pop on the same edge.
        clear_bench();
        ack_lat = 0;
        rd_lo   = 2;
        rd_hi   = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NP; i++) begin
                port_q[i].push_back('{addr: AW'($urandom), data: $urandom, we: 1'b0});
            end
        end
        wait_drain(400, "pushpop");
        check("pushpop_coincide", 64'(coincide_seen), 64'd1);
        check("pushpop_valid0", 64'(valid_cnt[0]), 64'd4);
        check("pushpop_valid1", 64'(valid_cnt[1]), 64'd4);
        check("pushpop_no_orphan", 64'(err_orphan), 64'd0);

        // Orphan return: dropped, no p_valid, sticky flag.
        clear_bench();
        orphan_pulse = 1'b1;
        tick(3);
        check("orphan_flag", 64'(err_orphan), 64'd1);
        check("orphan_no_valid0", 64'(valid_cnt[0]), 64'd0);
        check("orphan_no_valid1", 64'(valid_cnt[1]), 64'd0);
        tick(5);
        check("orphan_sticky", 64'(err_orphan), 64'd1);

        // Reset while a command is waiting for ack; round-robin restarts at port 0.
        clear_bench();
        port_q[0].push_back('{addr: 23'h42, data: '0, we: 1'b0});
        wait_drain(100, "prereset");
        ack_lat = 30;
        port_q[0].push_back('{addr: 23'h43, data: '0, we: 1'b0});
        tick(6);
        check("midissue_req", 64'(ctrl_req), 64'd1);
        reset_n = 1'b0;
        tick(1);
        check_outputs_zero("midissue");
        port_q[1].push_back('{addr: 23'h44, data: '0, we: 1'b0});
        tick(2);
        ack_log.delete();
        ack_lat = 0;
        reset_n = 1'b1;
        wait_drain(100, "postreset");
        check("postreset_acks", 64'(ack_log.size()), 64'd2);
        if (ack_log.size() > 0) check("postreset_first_port", 64'(ack_log[0]), 64'd0);

        // Random traffic against the scoreboard.
        gap_pct = 30;
        for (int ph = 0; ph < 4; ph++) begin
            clear_bench();
            ack_lat = $urandom_range(3);
            rd_lo   = 1;
            rd_hi   = 6;
            for (int k = 0; k < 30; k++) begin
                for (int i = 0; i < NP; i++) begin
                    port_q[i].push_back('{addr: AW'($urandom), data: $urandom,
                                          we: 1'($urandom_range(1))});
                end
            end
            wait_drain(3000, $sformatf("rand%0d", ph));
            check($sformatf("rand%0d_acks0", ph), 64'(ack_cnt[0]), 64'd30);
            check($sformatf("rand%0d_acks1", ph), 64'(ack_cnt[1]), 64'd30);
        end
        check("final_no_orphan", 64'(err_orphan), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
